// File: rtl/report_encoder.sv
// report_encoder: turns report-request pulses into ASCII report lines
// ("T=HH:MM:SS", "D=dddcm", "C=ddd", "H=ddd" plus EOL) streamed to a UART
// transmitter over a valid/ready handshake. Requests are latched as pending
// flags and served in fixed priority; sensor data is snapshotted as BCD at
// message start so input changes never corrupt a line in flight.
module report_encoder #(
  parameter int P_EOL_CRLF = 1
) (
  input  logic       iClk,
  input  logic       iRstn,
  input  logic       iReqWatchRpt,
  input  logic       iReqSr04Rpt,
  input  logic       iReqTempRpt,
  input  logic       iReqHumRpt,
  input  logic [4:0] iHour,
  input  logic [5:0] iMin,
  input  logic [5:0] iSec,
  input  logic [8:0] iDistCm,
  input  logic [7:0] iTemp,
  input  logic [7:0] iHum,
  output logic [7:0] oTxData,
  output logic       oTxValid,
  input  logic       iTxReady,
  output logic       oBusy
);

  typedef enum logic {S_IDLE, S_SEND} state_t;
  typedef enum logic [1:0] {M_WATCH, M_SR04, M_TEMP, M_HUM} msg_t;

  state_t      state_q, state_d;
  msg_t        msg_q, msg_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  idx_q, idx_d;
  logic [23:0] dig_q, dig_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;

  logic [3:0]  req;
  msg_t        sel;
  logic [23:0] snap;
  logic [11:0] bcd_h, bcd_m, bcd_s, bcd_dist, bcd_temp, bcd_hum;

  // Shift-and-add-3 binary to three BCD digits {hundreds, tens, ones}.
  function automatic logic [11:0] bin2bcd(input logic [8:0] b);
    logic [20:0] sr;
    sr = {12'd0, b};
    for (int i = 0; i < 9; i++) begin
      if (sr[12:9]  >= 4'd5) sr[12:9]  = sr[12:9]  + 4'd3;
      if (sr[16:13] >= 4'd5) sr[16:13] = sr[16:13] + 4'd3;
      if (sr[20:17] >= 4'd5) sr[20:17] = sr[20:17] + 4'd3;
      sr = sr << 1;
    end
    return sr[20:9];
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] d);
    return 8'h30 + {4'd0, d};
  endfunction

  // Number of bytes before the end-of-line sequence.
  function automatic logic [3:0] body_len(input msg_t m);
    case (m)
      M_WATCH: return 4'd10;
      M_SR04:  return 4'd7;
      default: return 4'd5;
    endcase
  endfunction

  function automatic logic [3:0] last_idx(input msg_t m);
    return body_len(m) + ((P_EOL_CRLF != 0) ? 4'd1 : 4'd0);
  endfunction

  // Byte i of message m, digits d packed most-significant nibble first.
  function automatic logic [7:0] byte_at(input msg_t m, input logic [3:0] i,
                                         input logic [23:0] d);
    logic [7:0] b;
    b = 8'h00;
    if (i >= body_len(m)) begin
      b = ((P_EOL_CRLF != 0) && (i == body_len(m))) ? 8'h0D : 8'h0A;
    end else begin
      case (m)
        M_WATCH:
          case (i)
            4'd0:    b = "T";
            4'd1:    b = "=";
            4'd2:    b = asc(d[23:20]);
            4'd3:    b = asc(d[19:16]);
            4'd4:    b = ":";
            4'd5:    b = asc(d[15:12]);
            4'd6:    b = asc(d[11:8]);
            4'd7:    b = ":";
            4'd8:    b = asc(d[7:4]);
            default: b = asc(d[3:0]);
          endcase
        M_SR04:
          case (i)
            4'd0:    b = "D";
            4'd1:    b = "=";
            4'd2:    b = asc(d[23:20]);
            4'd3:    b = asc(d[19:16]);
            4'd4:    b = asc(d[15:12]);
            4'd5:    b = "c";
            default: b = "m";
          endcase
        default:
          case (i)
            4'd0:    b = (m == M_TEMP) ? "C" : "H";
            4'd1:    b = "=";
            4'd2:    b = asc(d[23:20]);
            4'd3:    b = asc(d[19:16]);
            default: b = asc(d[15:12]);
          endcase
      endcase
    end
    return b;
  endfunction

  assign req      = {iReqHumRpt, iReqTempRpt, iReqSr04Rpt, iReqWatchRpt};
  assign bcd_h    = bin2bcd({4'd0, iHour});
  assign bcd_m    = bin2bcd({3'd0, iMin});
  assign bcd_s    = bin2bcd({3'd0, iSec});
  assign bcd_dist = bin2bcd(iDistCm);
  assign bcd_temp = bin2bcd({1'b0, iTemp});
  assign bcd_hum  = bin2bcd({1'b0, iHum});

  // Pick the highest-priority pending request and build its digit snapshot.
  always_comb begin
    sel  = M_HUM;
    snap = {bcd_hum, 12'd0};
    if (pend_q[0]) begin
      sel  = M_WATCH;
      snap = {bcd_h[7:0], bcd_m[7:0], bcd_s[7:0]};
    end else if (pend_q[1]) begin
      sel  = M_SR04;
      snap = {bcd_dist, 12'd0};
    end else if (pend_q[2]) begin
      sel  = M_TEMP;
      snap = {bcd_temp, 12'd0};
    end
  end

  // Next-state logic: request latching, message start and byte streaming.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    pend_d  = pend_q | req;
    idx_d   = idx_q;
    dig_d   = dig_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          msg_d   = sel;
          dig_d   = snap;
          pend_d  = (pend_q & ~(4'b0001 << sel)) | req;
          idx_d   = 4'd0;
          data_d  = byte_at(sel, 4'd0, snap);
          valid_d = 1'b1;
          state_d = S_SEND;
        end
      end
      default: begin
        if (valid_q && iTxReady) begin
          if (idx_q == last_idx(msg_q)) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = byte_at(msg_q, idx_q + 4'd1, dig_q);
          end
        end
      end
    endcase
  end

  // State, flag and output registers; reset aborts any message in flight.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q <= S_IDLE;
      msg_q   <= M_WATCH;
      pend_q  <= 4'd0;
      idx_q   <= 4'd0;
      dig_q   <= 24'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign oTxData  = data_q;
  assign oTxValid = valid_q;
  assign oBusy    = (state_q == S_SEND);

endmodule
